pattern_scan_scheduler: RTL and testbench

//   Shares one serial 1101 pattern detector between NUM_REQ requesters. Each requester submits a

---
 rtl/pattern_scan_pkg.sv | 5 +
 rtl/pattern_scan_scheduler_if.sv | 26 ++
 rtl/serial_pattern_fsm.sv | 35 +++
 rtl/pattern_scan_scheduler.sv | 80 ++++++++
 tb/tb_pattern_scan_scheduler.sv | 118 +++++++++++
 5 files changed

// File: rtl/pattern_scan_pkg.sv
// pattern_scan_pkg: shared state encodings for the pattern scan scheduler and its detector.
package pattern_scan_pkg;
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} ctrl_t;
    typedef enum logic [2:0] {S0, S1, S2, S3, S4, S5, S6, S7} det_t;
endpackage

// File: rtl/pattern_scan_scheduler_if.sv
// pattern_scan_scheduler_if: request/response bus between requesters, consumer and the scheduler.
interface pattern_scan_scheduler_if #(
    parameter int NUM_REQ = 4,
    parameter int WORD_W  = 16,
    parameter int ID_W    = $clog2(NUM_REQ),
    parameter int CNT_W   = $clog2(WORD_W + 1)
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*WORD_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [ID_W-1:0]           rsp_id;
    logic [CNT_W-1:0]          rsp_count;
    logic                      rsp_halted;
    logic [CNT_W-1:0]          rsp_bits_used;
    logic                      busy;
    modport master (
        output req_valid, req_data, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_count, rsp_halted, rsp_bits_used, busy
    );
    modport slave (
        input  req_valid, req_data, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_count, rsp_halted, rsp_bits_used, busy
    );
endinterface

// File: rtl/serial_pattern_fsm.sv
// serial_pattern_fsm: 8-state serial detector counting 1101 hits and halting on 1000.
module serial_pattern_fsm
    import pattern_scan_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic bit_en,
    input  logic bit_in,
    output logic hit,
    output logic stop,
    output logic halted
);
    det_t state, nxt;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= S0;
        else if (clr) state <= S0;
        else if (bit_en) state <= nxt;
    always_comb begin
        nxt = state;
        case (state)
            S0: nxt = bit_in ? S1 : S0;
            S1: nxt = bit_in ? S2 : S5;
            S2: nxt = bit_in ? S2 : S3;
            S3: nxt = bit_in ? S4 : S6;
            S4: nxt = bit_in ? S2 : S5;
            S5: nxt = bit_in ? S1 : S6;
            S6: nxt = bit_in ? S1 : S7;
            default: nxt = S7;
        endcase
    end
    assign hit    = bit_en & (nxt == S4);
    assign stop   = bit_en & (nxt == S7);
    assign halted = state == S7;
endmodule

// File: rtl/pattern_scan_scheduler.sv
// pattern_scan_scheduler: round-robin shares one serial 1101/1000 detector between NUM_REQ requesters.
module pattern_scan_scheduler
    import pattern_scan_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WORD_W  = 16
) (
    input logic clk,
    input logic rst_n,
    pattern_scan_scheduler_if.slave bus
);
    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(WORD_W + 1);
    ctrl_t             state, nxt;
    logic [ID_W-1:0]   ptr, gnt, id;
    logic              found, hit, stop, halted, take;
    logic [WORD_W-1:0] shreg;
    logic [CNT_W-1:0]  count, bits;
    // Scan downwards so the first valid index at or after ptr is the one kept.
    always_comb begin
        found = 1'b0;
        gnt   = ptr;
        for (int i = NUM_REQ - 1; i >= 0; i--)
            if (bus.req_valid[(int'(ptr) + i) % NUM_REQ]) begin
                found = 1'b1;
                gnt   = ID_W'((int'(ptr) + i) % NUM_REQ);
            end
    end
    assign take = (state == IDLE) && found;
    always_comb begin
        bus.req_ready = '0;
        if (take) bus.req_ready[gnt] = 1'b1;
    end
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = found ? SHIFT : IDLE;
            SHIFT:   nxt = (stop || bits == CNT_W'(WORD_W - 1)) ? DONE : SHIFT;
            default: nxt = bus.rsp_ready ? IDLE : DONE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state <= IDLE;
            ptr   <= '0;
            id    <= '0;
            shreg <= '0;
            count <= '0;
            bits  <= '0;
        end else begin
            state <= nxt;
            if (take) begin
                shreg <= bus.req_data[gnt*WORD_W +: WORD_W];
                id    <= gnt;
                count <= '0;
                bits  <= '0;
                ptr   <= (gnt == ID_W'(NUM_REQ - 1)) ? '0 : gnt + ID_W'(1);
            end else if (state == SHIFT) begin
                shreg <= {shreg[WORD_W-2:0], 1'b0};
                bits  <= bits + CNT_W'(1);
                count <= count + CNT_W'(hit);
            end
        end
    serial_pattern_fsm u_det (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (take),
        .bit_en (state == SHIFT),
        .bit_in (shreg[WORD_W-1]),
        .hit    (hit),
        .stop   (stop),
        .halted (halted)
    );
    assign bus.rsp_valid     = state == DONE;
    assign bus.rsp_id        = id;
    assign bus.rsp_count     = count;
    assign bus.rsp_halted    = halted;
    assign bus.rsp_bits_used = bits;
    assign bus.busy          = state != IDLE;
endmodule

// File: tb/tb_pattern_scan_scheduler.sv
// tb_pattern_scan_scheduler: directed and randomized jobs checked against a substring-based scan model.
module tb_pattern_scan_scheduler;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int compares = 0;
    int fails = 0;
    int ptr = 0;
    pattern_scan_scheduler_if #(.NUM_REQ(4), .WORD_W(16)) bus ();
    pattern_scan_scheduler #(.NUM_REQ(4), .WORD_W(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compares++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask
    function automatic int pick(input logic [3:0] v, input int p);
        for (int i = 0; i < 4; i++) if (v[(p + i) % 4]) return (p + i) % 4;
        return -1;
    endfunction
    // Reference: last four bits seen since the job began; 1101 is a hit, 1000 ends the scan.
    task automatic ref_scan(input logic [15:0] w, output int c, output int h, output int b);
        int win = 0;
        c = 0; h = 0; b = 0;
        for (int i = 15; i >= 0; i--) begin
            win = ((win << 1) | int'(w[i])) & 15;
            b++;
            if (b >= 4 && win == 13) c++;
            if (b >= 4 && win == 8) begin h = 1; break; end
        end
    endtask
    // Called just after a negedge with the DUT idle and req_valid already driven.
    task automatic serve(input bit drop, input int hold);
        int g, ec, eh, eb, cyc;
        logic [15:0] w;
        #1;
        g = pick(bus.req_valid, ptr);
        chk("grant", 32'(bus.req_ready), 32'(1 << g));
        w = bus.req_data[g*16 +: 16];
        ref_scan(w, ec, eh, eb);
        @(negedge clk);
        if (drop) bus.req_valid[g] = 1'b0;
        ptr = (g + 1) % 4;
        chk("busy", 32'(bus.busy), 32'd1);
        cyc = 1;
        while (!bus.rsp_valid && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        chk("latency", 32'(cyc), 32'(eb + 1));
        chk("rsp_id", 32'(bus.rsp_id), 32'(g));
        chk("rsp_count", 32'(bus.rsp_count), 32'(ec));
        chk("rsp_halted", 32'(bus.rsp_halted), 32'(eh));
        chk("rsp_bits_used", 32'(bus.rsp_bits_used), 32'(eb));
        repeat (hold) begin
            @(negedge clk);
            chk("hold_rsp", {bus.rsp_valid, 5'(bus.rsp_id), 5'(bus.rsp_count), bus.rsp_halted, 5'(bus.rsp_bits_used)},
                {1'b1, 5'(g), 5'(ec), 1'(eh), 5'(eb)});
            chk("hold_ready", 32'(bus.req_ready), 32'd0);
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        chk("back_idle", {bus.busy, bus.rsp_valid}, 32'd0);
    endtask
    initial begin
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.rsp_ready = 1'b0;
        #2;
        chk("reset_out", {bus.req_ready, bus.rsp_valid, bus.rsp_id, bus.rsp_count, bus.rsp_halted, bus.rsp_bits_used, bus.busy}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        bus.req_data[0*16 +: 16] = 16'hDDDD;
        bus.req_valid = 4'b0001;
        serve(1'b1, 0);
        chk("dddd_count", 32'(bus.rsp_count), 32'd4);
        bus.req_data[1*16 +: 16] = 16'hD800;
        bus.req_valid = 4'b0010;
        serve(1'b1, 0);
        chk("d800_bits", {bus.rsp_halted, 5'(bus.rsp_bits_used)}, {1'b1, 5'd8});
        bus.req_data[3*16 +: 16] = 16'h0000;
        bus.req_valid = 4'b1000;
        serve(1'b1, 0);
        bus.req_data[1*16 +: 16] = 16'hFFFF;
        bus.req_valid = 4'b0010;
        @(negedge clk);
        bus.req_valid = 4'b0000;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midjob_reset", {bus.req_ready, bus.rsp_valid, bus.rsp_id, bus.rsp_count, bus.rsp_halted, bus.rsp_bits_used, bus.busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ptr = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("no_rsp_after_drop", {bus.rsp_valid, bus.busy}, 32'd0);
        end
        bus.req_data[0*16 +: 16] = 16'h1234;
        bus.req_data[2*16 +: 16] = 16'hDDD0;
        bus.req_valid = 4'b0101;
        serve(1'b0, 0);
        serve(1'b1, 10);
        serve(1'b1, 0);
        for (int r = 0; r < 30; r++) begin
            bus.req_valid = 4'($urandom_range(1, 15));
            for (int k = 0; k < 4; k++)
                bus.req_data[k*16 +: 16] = ($urandom_range(0, 3) == 0) ? 16'hDDDD ^ 16'($urandom_range(0, 15)) : 16'($urandom);
            serve(1'($urandom_range(0, 1)), $urandom_range(0, 3));
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
        $finish;
    end
endmodule
